// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instruction_fetch_pkg;

    localparam int          INSTR_WIDTH    = 32;
    localparam logic [31:0] PC_INC         = 32'd4;
    localparam logic [31:0] PC_READ_OFFSET = 32'd8;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: decode/register-file controls, instruction memory port and presented instruction.
interface instruction_fetch_if;
    import instruction_fetch_pkg::*;

    logic                   stall;
    logic                   writeToPC;
    logic [31:0]            pcWriteData;
    logic                   branchTaken;
    logic [23:0]            branchOffset;
    logic                   imemReq;
    logic [31:0]            imemAddr;
    logic                   imemValid;
    logic [INSTR_WIDTH-1:0] imemData;
    logic [INSTR_WIDTH-1:0] instrOut;
    logic                   instrValid;
    logic [31:0]            instrPC;
    logic [31:0]            oldPCVal;

    modport master (
        input  stall, writeToPC, pcWriteData, branchTaken, branchOffset, imemValid, imemData,
        output imemReq, imemAddr, instrOut, instrValid, instrPC, oldPCVal
    );

    modport slave (
        output stall, writeToPC, pcWriteData, branchTaken, branchOffset, imemValid, imemData,
        input  imemReq, imemAddr, instrOut, instrValid, instrPC, oldPCVal
    );

endinterface

// File: rtl/instruction_fetch_pc_next_logic.sv
// Redirect priority and target generation: an R15 write beats a branch taken on a consume cycle.
module pc_next_logic
    import instruction_fetch_pkg::*;
(
    input  logic        write_to_pc,
    input  logic [31:0] pc_write_data,
    input  logic        branch_taken,
    input  logic [23:0] branch_offset,
    input  logic        consume,
    input  logic [31:0] instr_pc,
    output logic        redirect,
    output logic [31:0] target
);

    logic [31:0] branch_target;

    assign branch_target = instr_pc + PC_READ_OFFSET
                         + {{6{branch_offset[23]}}, branch_offset, 2'b00};

    // NOTE: both outputs get a default before any branch so no latch is inferred.
    always_comb begin
        redirect = 1'b0;
        target   = branch_target;
        if (write_to_pc) begin
            redirect = 1'b1;
            target   = {pc_write_data[31:2], 2'b00};
        end else if (branch_taken && consume) begin
            redirect = 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one instruction-memory request at a time, presents one instruction to decode.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    instruction_fetch_if.master bus
);

    fetch_state_t           state;
    logic [31:0]            pc;
    logic                   squash;
    logic                   imem_req;
    logic [31:0]            imem_addr;
    logic [INSTR_WIDTH-1:0] instr_out;
    logic                   instr_valid;
    logic [31:0]            instr_pc;

    logic                   consume;
    logic                   redirect;
    logic [31:0]            target;
    logic [31:0]            fetch_pc;

    assign consume  = instr_valid && !bus.stall;
    assign fetch_pc = redirect ? target : pc;

    pc_next_logic u_pc_next (
        .write_to_pc   (bus.writeToPC),
        .pc_write_data (bus.pcWriteData),
        .branch_taken  (bus.branchTaken),
        .branch_offset (bus.branchOffset),
        .consume       (consume),
        .instr_pc      (instr_pc),
        .redirect      (redirect),
        .target        (target)
    );

    assign bus.imemReq    = imem_req;
    assign bus.imemAddr   = imem_addr;
    assign bus.instrOut   = instr_out;
    assign bus.instrValid = instr_valid;
    assign bus.instrPC    = instr_pc;
    assign bus.oldPCVal   = instr_pc + PC_READ_OFFSET;

    // NOTE: imem_addr is separate from pc so a redirect can move pc while the request is outstanding.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            squash      <= 1'b0;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            instr_pc    <= '0;
        end else begin
            imem_req <= 1'b0;
            unique case (state)
                IDLE: begin
                    pc        <= fetch_pc;
                    imem_req  <= 1'b1;
                    imem_addr <= fetch_pc;
                    state     <= FETCH;
                end
                FETCH: begin
                    if (redirect) begin
                        pc     <= target;
                        squash <= 1'b1;
                    end
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.imemValid) begin
                        if (squash || redirect) begin
                            squash    <= 1'b0;
                            pc        <= fetch_pc;
                            imem_req  <= 1'b1;
                            imem_addr <= fetch_pc;
                            state     <= FETCH;
                        end else begin
                            instr_out   <= bus.imemData;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                            pc          <= pc + PC_INC;
                            state       <= HOLD;
                        end
                    end else if (redirect) begin
                        pc     <= target;
                        squash <= 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.writeToPC || consume) begin
                        instr_valid <= 1'b0;
                        pc          <= fetch_pc;
                        imem_req    <= 1'b1;
                        imem_addr   <= fetch_pc;
                        state       <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
